rf_seq_ctrl: RTL

RF_SEQ_CTRL -- requirements
Module: rf_seq_ctrl

---
 rtl/rf_seq_ctrl_if.sv | 49 ++++
 rtl/rf_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_seq_ctrl_if.sv
// Bundle of the host command port, the RF serial-interface access port,
// the received-byte stream and the status outputs of rf_seq_ctrl.
//
// Handshakes (cmd_valid/cmd_ready, rx_valid/rx_ready): a transfer happens on
// a rising clk edge where both valid and ready are high. The source holds
// valid and its payload stable until that edge and never withdraws valid
// early. The sink may raise or drop ready freely.
interface rf_seq_ctrl_if;
    // host command port
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_inst;
    logic [9:0] cmd_addr;
    logic [7:0] cmd_wdata;
    // RF serial-interface access port
    logic [9:0] rf_addr;
    logic [7:0] rf_wdata;
    logic [1:0] rf_inst;
    logic       rf_cs;
    logic       rf_ready;
    logic [7:0] rf_rdata;
    logic       rf_intr;
    logic       rf_rst_n;
    // received-byte stream
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_last;
    logic       rx_ready;
    // status
    logic       busy;
    logic       timeout_err;
    logic [7:0] intstat;

    // controller side
    modport master (
        input  cmd_valid, cmd_inst, cmd_addr, cmd_wdata,
        input  rf_ready, rf_rdata, rf_intr, rx_ready,
        output cmd_ready, rf_addr, rf_wdata, rf_inst, rf_cs, rf_rst_n,
        output rx_data, rx_valid, rx_last, busy, timeout_err, intstat
    );

    // host / transceiver / stream-consumer side
    modport slave (
        output cmd_valid, cmd_inst, cmd_addr, cmd_wdata,
        output rf_ready, rf_rdata, rf_intr, rx_ready,
        input  cmd_ready, rf_addr, rf_wdata, rf_inst, rf_cs, rf_rst_n,
        input  rx_data, rx_valid, rx_last, busy, timeout_err, intstat
    );
endinterface

// File: rtl/rf_seq_ctrl.sv
// RF transceiver sequencer: runs the transceiver power-up reset, forwards
// single host register accesses to the RF serial interface, and on an
// interrupt reads the interrupt status register and drains RX_BYTES bytes
// from the RX FIFO into a valid/ready byte stream.
module rf_seq_ctrl #(
    parameter int         RST_LOW_CYC  = 50000,
    parameter int         RST_WAIT_CYC = 110000,
    parameter int         RX_BYTES     = 8,
    parameter logic [9:0] RX_BASE      = 10'h300,
    parameter logic [5:0] INTSTAT_ADDR = 6'h31,
    parameter int         GUARD_CYC    = 3,
    parameter int         TIMEOUT_CYC  = 4096
) (
    input  logic           clk,
    input  logic           rst,
    rf_seq_ctrl_if.master  bus,
    output logic [3:0]     dbg_state
);

    localparam int MAX_AB = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int MAX_C  = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] RST_LO_LAST = CW'((RST_LOW_CYC  > 0) ? RST_LOW_CYC  - 1 : 0);
    localparam logic [CW-1:0] RST_WT_LAST = CW'((RST_WAIT_CYC > 0) ? RST_WAIT_CYC - 1 : 0);
    localparam logic [CW-1:0] GUARD_LAST  = CW'((GUARD_CYC    > 0) ? GUARD_CYC    - 1 : 0);
    localparam logic [CW-1:0] TO_LAST     = CW'((TIMEOUT_CYC  > 0) ? TIMEOUT_CYC  - 1 : 0);
    localparam logic [7:0]    RX_LAST_IDX = 8'(RX_BYTES - 1);

    localparam logic [1:0] INST_SHORT_RD = 2'b00;
    localparam logic [1:0] INST_LONG_RD  = 2'b10;

    typedef enum logic [3:0] {
        S_RST_LO   = 4'd0,
        S_RST_WAIT = 4'd1,
        S_IDLE     = 4'd2,
        S_ISSUE    = 4'd3,
        S_GUARD    = 4'd4,
        S_WAIT_RDY = 4'd5,
        S_INT_RD   = 4'd6,
        S_RX_RD    = 4'd7,
        S_RX_OUT   = 4'd8
    } state_t;

    // who started the current access, i.e. where WAIT_RDY returns to
    typedef enum logic [1:0] {
        CTX_CMD = 2'd0,
        CTX_INT = 2'd1,
        CTX_RX  = 2'd2
    } ctx_t;

    state_t        state_q, state_d;
    ctx_t          ctx_q, ctx_d;
    logic          ret_q, ret_d;          // set when an access has just completed
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    idx_q, idx_d;
    logic          rf_rst_n_q, rf_rst_n_d;
    logic          rf_cs_q, rf_cs_d;
    logic [9:0]    rf_addr_q, rf_addr_d;
    logic [7:0]    rf_wdata_q, rf_wdata_d;
    logic [1:0]    rf_inst_q, rf_inst_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_last_q, rx_last_d;
    logic          busy_q, busy_d;
    logic          timeout_err_q, timeout_err_d;
    logic [7:0]    intstat_q, intstat_d;

    // next-state and next-output logic; every output is registered
    always_comb begin
        state_d       = state_q;
        ctx_d         = ctx_q;
        ret_d         = ret_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        rf_rst_n_d    = rf_rst_n_q;
        rf_cs_d       = rf_cs_q;
        rf_addr_d     = rf_addr_q;
        rf_wdata_d    = rf_wdata_q;
        rf_inst_d     = rf_inst_q;
        cmd_ready_d   = cmd_ready_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        rx_last_d     = rx_last_q;
        busy_d        = busy_q;
        timeout_err_d = timeout_err_q;
        intstat_d     = intstat_q;

        case (state_q)
            S_RST_LO: begin
                if (cnt_q == RST_LO_LAST) begin
                    cnt_d      = '0;
                    rf_rst_n_d = 1'b1;
                    state_d    = S_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RST_WAIT: begin
                if (cnt_q == RST_WT_LAST) begin
                    cnt_d       = '0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_IDLE: begin
                // the interrupt has priority; the command waits in that case
                if (bus.rf_intr) begin
                    ctx_d       = CTX_INT;
                    ret_d       = 1'b0;
                    rf_addr_d   = {4'b0000, INTSTAT_ADDR};
                    rf_inst_d   = INST_SHORT_RD;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_INT_RD;
                end else if (bus.cmd_valid) begin
                    ctx_d       = CTX_CMD;
                    rf_addr_d   = bus.cmd_inst[1] ? bus.cmd_addr
                                                  : {4'b0000, bus.cmd_addr[5:0]};
                    rf_inst_d   = bus.cmd_inst;
                    rf_wdata_d  = bus.cmd_wdata;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // first cycle only sets up so the address leads rf_cs by a cycle
                if (!rf_cs_q) begin
                    rf_cs_d = 1'b1;
                end else begin
                    rf_cs_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_GUARD;
                end
            end

            S_GUARD: begin
                if (cnt_q >= GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RDY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_RDY: begin
                if (bus.rf_ready) begin
                    cnt_d = '0;
                    case (ctx_q)
                        CTX_INT: begin
                            intstat_d = bus.rf_rdata;
                            ret_d     = 1'b1;
                            state_d   = S_INT_RD;
                        end
                        CTX_RX: begin
                            rx_data_d = bus.rf_rdata;
                            ret_d     = 1'b1;
                            state_d   = S_RX_RD;
                        end
                        default: begin
                            cmd_ready_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = S_IDLE;
                        end
                    endcase
                end else if (cnt_q == TO_LAST) begin
                    // give up on the whole sequence, not only this access
                    cnt_d         = '0;
                    idx_d         = '0;
                    ret_d         = 1'b0;
                    timeout_err_d = 1'b1;
                    cmd_ready_d   = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_INT_RD: begin
                if (!ret_q) begin
                    state_d = S_ISSUE;
                end else begin
                    ret_d = 1'b0;
                    if (intstat_q[3]) begin
                        ctx_d     = CTX_RX;
                        idx_d     = '0;
                        rf_addr_d = RX_BASE;
                        rf_inst_d = INST_LONG_RD;
                        state_d   = S_RX_RD;
                    end else begin
                        cmd_ready_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_RX_RD: begin
                if (!ret_q) begin
                    state_d = S_ISSUE;
                end else begin
                    ret_d      = 1'b0;
                    rx_valid_d = 1'b1;
                    rx_last_d  = (idx_q == RX_LAST_IDX);
                    state_d    = S_RX_OUT;
                end
            end

            S_RX_OUT: begin
                // no further FIFO read until the consumer takes this byte
                if (bus.rx_ready) begin
                    rx_valid_d = 1'b0;
                    rx_last_d  = 1'b0;
                    if (rx_last_q) begin
                        idx_d       = '0;
                        cmd_ready_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        rf_addr_d = RX_BASE + {2'b00, idx_q + 8'd1};
                        state_d   = S_RX_RD;
                    end
                end
            end

            default: begin
                state_d = S_RST_LO;
            end
        endcase
    end

    // state and output registers, cleared asynchronously into the power-up sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RST_LO;
            ctx_q         <= CTX_CMD;
            ret_q         <= 1'b0;
            cnt_q         <= '0;
            idx_q         <= '0;
            rf_rst_n_q    <= 1'b0;
            rf_cs_q       <= 1'b0;
            rf_addr_q     <= '0;
            rf_wdata_q    <= '0;
            rf_inst_q     <= '0;
            cmd_ready_q   <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_last_q     <= 1'b0;
            busy_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            intstat_q     <= '0;
        end else begin
            state_q       <= state_d;
            ctx_q         <= ctx_d;
            ret_q         <= ret_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            rf_rst_n_q    <= rf_rst_n_d;
            rf_cs_q       <= rf_cs_d;
            rf_addr_q     <= rf_addr_d;
            rf_wdata_q    <= rf_wdata_d;
            rf_inst_q     <= rf_inst_d;
            cmd_ready_q   <= cmd_ready_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_last_q     <= rx_last_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            intstat_q     <= intstat_d;
        end
    end

    assign bus.rf_rst_n    = rf_rst_n_q;
    assign bus.rf_cs       = rf_cs_q;
    assign bus.rf_addr     = rf_addr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.rf_inst     = rf_inst_q;
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_last     = rx_last_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.intstat     = intstat_q;
    assign dbg_state       = state_q;

endmodule
